// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the datapath divide resource.
// Holds the divider FSM state type, default operand width and counter sizing.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 8;

    // Bits needed to count WIDTH iterations (0 .. WIDTH-1).
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor (x + ~y + 1) and keep or restore.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   p_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   p_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // Trial subtraction one bit wider than P so the top bit is the borrow.
    always_comb begin
        shifted = {p_in, bit_in};
        diff    = shifted + ~{2'b00, divisor} + {{(WIDTH+1){1'b0}}, 1'b1};
        q_bit   = ~diff[WIDTH+1];
        p_out   = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/seq_divider8.sv
// Sequential restoring divider, one quotient bit per clock, with a
// start/busy/done handshake. Results and div_by_zero are held until the
// next completion.
// Optional build macro SEQ_DIVIDER8_SIGNED_EN: two's-complement operands,
// magnitudes divided then one extra sign fix-up cycle before done.
module seq_divider8
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH:0]   p_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic             zero_pend_reg;
    logic             done_reg;
    logic             dbz_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;

    logic             accept;
    logic             divisor_zero;
    logic             iterate;
    logic             last_iter;
    logic             complete;
    logic [WIDTH:0]   p_step;
    logic             q_bit;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH-1:0] dividend_load;
    logic [WIDTH-1:0] divisor_load;

`ifdef SEQ_DIVIDER8_SIGNED_EN
    logic             fix_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic [WIDTH-1:0] q_fixed;
    logic [WIDTH-1:0] r_fixed;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .p_in    (p_reg),
        .bit_in  (q_reg[WIDTH-1]),
        .divisor (d_reg),
        .p_out   (p_step),
        .q_bit   (q_bit)
    );

    assign q_shift = {q_reg[WIDTH-2:0], q_bit};

    // Operand conditioning on load and sign restoration of the results.
    always_comb begin
        divisor_zero = (divisor == '0);
`ifdef SEQ_DIVIDER8_SIGNED_EN
        divisor_load  = divisor[WIDTH-1] ? (~divisor + WIDTH'(1)) : divisor;
        // A zero divisor skips iteration, so keep the raw dividend for the remainder.
        dividend_load = (divisor_zero || !dividend[WIDTH-1]) ? dividend
                                                              : (~dividend + WIDTH'(1));
        q_fixed = neg_q_reg ? (~q_reg + WIDTH'(1)) : q_reg;
        r_fixed = neg_r_reg ? (~p_reg[WIDTH-1:0] + WIDTH'(1)) : p_reg[WIDTH-1:0];
`else
        divisor_load  = divisor;
        dividend_load = dividend;
`endif
    end

    // Handshake decode and next-state logic.
    always_comb begin
        busy    = (state_reg == RUN) || zero_pend_reg;
        accept  = start && !busy && ((state_reg == IDLE) || (state_reg == DONE));
`ifdef SEQ_DIVIDER8_SIGNED_EN
        iterate   = (state_reg == RUN) && !fix_reg;
        last_iter = iterate && (cnt_reg == LAST_CNT);
        complete  = (state_reg == RUN) && fix_reg;
`else
        iterate   = (state_reg == RUN);
        last_iter = iterate && (cnt_reg == LAST_CNT);
        complete  = last_iter;
`endif
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = divisor_zero ? DONE : RUN;
            end
            RUN: begin
                if (complete) state_next = DONE;
            end
            DONE: begin
                // A zero-divisor request waits here one cycle before its done pulse.
                if (accept)              state_next = divisor_zero ? DONE : RUN;
                else if (!zero_pend_reg) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Datapath: operand latch, iteration, completion and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            p_reg         <= '0;
            q_reg         <= '0;
            d_reg         <= '0;
            zero_pend_reg <= 1'b0;
            done_reg      <= 1'b0;
            dbz_reg       <= 1'b0;
            quo_reg       <= '0;
            rem_reg       <= '0;
`ifdef SEQ_DIVIDER8_SIGNED_EN
            fix_reg       <= 1'b0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
`endif
        end else begin
            done_reg <= complete || zero_pend_reg;
            if (accept) begin
                cnt_reg       <= '0;
                p_reg         <= '0;
                q_reg         <= dividend_load;
                d_reg         <= divisor_load;
                zero_pend_reg <= divisor_zero;
`ifdef SEQ_DIVIDER8_SIGNED_EN
                fix_reg       <= 1'b0;
                neg_q_reg     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                neg_r_reg     <= dividend[WIDTH-1];
`endif
            end else if (iterate) begin
                p_reg   <= p_step;
                q_reg   <= q_shift;
                cnt_reg <= cnt_reg + CNT_W'(1);
                if (last_iter) begin
`ifdef SEQ_DIVIDER8_SIGNED_EN
                    fix_reg <= 1'b1;
`else
                    quo_reg <= q_shift;
                    rem_reg <= p_step[WIDTH-1:0];
                    dbz_reg <= 1'b0;
`endif
                end
`ifdef SEQ_DIVIDER8_SIGNED_EN
            end else if (complete) begin
                quo_reg <= q_fixed;
                rem_reg <= r_fixed;
                dbz_reg <= 1'b0;
                fix_reg <= 1'b0;
`endif
            end else if (zero_pend_reg) begin
                quo_reg       <= '1;
                rem_reg       <= q_reg;
                dbz_reg       <= 1'b1;
                zero_pend_reg <= 1'b0;
            end
        end
    end

    assign done        = done_reg;
    assign quotient    = quo_reg;
    assign remainder   = rem_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider8.sv
// Self-checking bench for seq_divider8: directed cases plus random operands
// checked against an arithmetic reference model (unsigned, or signed when
// SEQ_DIVIDER8_SIGNED_EN is defined).
module tb_seq_divider8;

`ifdef SEQ_DIVIDER8_SIGNED_EN
    localparam int LAT_RUN = 9;
`else
    localparam int LAT_RUN = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = 8'd0;
    logic [7:0] divisor = 8'd0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_vec = 0;
    int n_bad = 0;

    seq_divider8 #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic on the operands.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic z, output int lat);
        if (b == 8'd0) begin
            q = 8'hFF; r = a; z = 1'b1; lat = 1;
        end else begin
            z = 1'b0; lat = LAT_RUN;
`ifdef SEQ_DIVIDER8_SIGNED_EN
            begin : sgn
                int sa;
                int sb;
                sa = int'($signed(a));
                sb = int'($signed(b));
                q = 8'(sa / sb);
                r = 8'(sa % sb);
            end
`else
            q = a / b;
            r = a % b;
`endif
        end
    endfunction

    // Issue one request and wait (bounded) for done; no checking here.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int busy_cycles,
                          output logic [7:0] q, output logic [7:0] r,
                          output logic z, output logic busy_at_done);
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; busy_cycles = 0;
        while (done !== 1'b1 && lat < 50) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        q = quotient; r = remainder; z = div_by_zero; busy_at_done = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (quotient !== 8'h00) begin n_bad++; $display("FAIL reset_quotient: got %h want 00", quotient); end
        n_vec++; if (remainder !== 8'h00) begin n_bad++; $display("FAIL reset_remainder: got %h want 00", remainder); end
        n_vec++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        rst = 1'b0;
        $display("reset: outputs checked after reset");
    endtask

    task automatic test_basic();
        int lat, bc; logic [7:0] q, r; logic z, bd;
`ifdef SEQ_DIVIDER8_SIGNED_EN
        logic [7:0] eq = 8'hF8, er = 8'h00;   // -56 / 7
`else
        logic [7:0] eq = 8'd28, er = 8'd4;
`endif
        run_op(8'd200, 8'd7, lat, bc, q, r, z, bd);
        $display("basic: 200/7 -> q=%0d r=%0d z=%b lat=%0d", q, r, z, lat);
        n_vec++; if (lat != LAT_RUN) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT_RUN); end
        n_vec++; if (bc != LAT_RUN) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, LAT_RUN); end
        n_vec++; if (bd !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done: got %b want 0", bd); end
        n_vec++; if (q !== eq) begin n_bad++; $display("FAIL basic_quotient: got %h want %h", q, eq); end
        n_vec++; if (r !== er) begin n_bad++; $display("FAIL basic_remainder: got %h want %h", r, er); end
        n_vec++; if (z !== 1'b0) begin n_bad++; $display("FAIL basic_dbz: got %b want 0", z); end
        @(negedge clk);
        n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        n_vec++; if (quotient !== eq) begin n_bad++; $display("FAIL basic_hold: got %h want %h", quotient, eq); end
    endtask

    task automatic test_div_zero();
        int lat, bc; logic [7:0] q, r; logic z, bd;
        run_op(8'd5, 8'd0, lat, bc, q, r, z, bd);
        $display("div_zero: 5/0 -> q=%h r=%h z=%b lat=%0d", q, r, z, lat);
        n_vec++; if (lat != 1) begin n_bad++; $display("FAIL dz_latency: got %0d want 1", lat); end
        n_vec++; if (q !== 8'hFF) begin n_bad++; $display("FAIL dz_quotient: got %h want ff", q); end
        n_vec++; if (r !== 8'd5) begin n_bad++; $display("FAIL dz_remainder: got %h want 05", r); end
        n_vec++; if (z !== 1'b1) begin n_bad++; $display("FAIL dz_flag: got %b want 1", z); end
        n_vec++; if (bd !== 1'b0) begin n_bad++; $display("FAIL dz_busy_at_done: got %b want 0", bd); end
        run_op(8'd9, 8'd3, lat, bc, q, r, z, bd);
        $display("div_zero: 9/3 -> q=%0d r=%0d z=%b lat=%0d", q, r, z, lat);
        n_vec++; if (q !== 8'd3 || r !== 8'd0) begin n_bad++; $display("FAIL dz_next_result: got q=%h r=%h want q=03 r=00", q, r); end
        n_vec++; if (z !== 1'b0) begin n_bad++; $display("FAIL dz_flag_clear: got %b want 0", z); end
        n_vec++; if (lat != LAT_RUN) begin n_bad++; $display("FAIL dz_next_latency: got %0d want %0d", lat, LAT_RUN); end
    endtask

`ifndef SEQ_DIVIDER8_SIGNED_EN
    task automatic test_boundaries();
        logic [7:0] ta [4] = '{8'd255, 8'd3,  8'd255, 8'd0};
        logic [7:0] tb [4] = '{8'd1,   8'd10, 8'd255, 8'd9};
        logic [7:0] tq [4] = '{8'd255, 8'd0,  8'd1,   8'd0};
        logic [7:0] tr [4] = '{8'd0,   8'd3,  8'd0,   8'd0};
        int lat, bc; logic [7:0] q, r; logic z, bd;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], lat, bc, q, r, z, bd);
            $display("boundary: %0d/%0d -> q=%0d r=%0d lat=%0d", ta[i], tb[i], q, r, lat);
            n_vec++;
            if (q !== tq[i] || r !== tr[i] || z !== 1'b0 || lat != LAT_RUN) begin
                n_bad++;
                $display("FAIL boundary_%0d: got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=0 lat=%0d",
                         i, q, r, z, lat, tq[i], tr[i], LAT_RUN);
            end
        end
    endtask
`else
    task automatic test_signed();
        logic [7:0] ta [3] = '{8'hF9, 8'h07, 8'h80};
        logic [7:0] tb [3] = '{8'h02, 8'hFE, 8'hFF};
        logic [7:0] tq [3] = '{8'hFD, 8'hFD, 8'h80};
        logic [7:0] tr [3] = '{8'hFF, 8'h01, 8'h00};
        int lat, bc; logic [7:0] q, r; logic z, bd;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], lat, bc, q, r, z, bd);
            $display("signed: %h/%h -> q=%h r=%h lat=%0d", ta[i], tb[i], q, r, lat);
            n_vec++;
            if (q !== tq[i] || r !== tr[i] || z !== 1'b0 || lat != 9) begin
                n_bad++;
                $display("FAIL signed_%0d: got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=0 lat=9",
                         i, q, r, z, lat, tq[i], tr[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int lat, bc, elat; logic [7:0] a, b, q, r, eq, er; logic z, ez, bd;
        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            model(a, b, eq, er, ez, elat);
            run_op(a, b, lat, bc, q, r, z, bd);
            $display("random[%0d]: %h/%h -> q=%h r=%h z=%b lat=%0d", i, a, b, q, r, z, lat);
            n_vec++;
            if (q !== eq || r !== er || z !== ez) begin
                n_bad++;
                $display("FAIL random_result: %h/%h got q=%h r=%h z=%b want q=%h r=%h z=%b", a, b, q, r, z, eq, er, ez);
            end
            n_vec++;
            if (lat != elat) begin
                n_bad++;
                $display("FAIL random_latency: %h/%h got %0d want %0d", a, b, lat, elat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd9; start = 1'b1;
        @(negedge clk);
        dividend = 8'd50; divisor = 8'd2;     // start stays high while busy
        lat = 0;
        while (done !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
        $display("back_to_back: first q=%0d r=%0d lat=%0d", quotient, remainder, lat);
        n_vec++; if (lat != LAT_RUN) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, LAT_RUN); end
        n_vec++; if (quotient !== 8'd11 || remainder !== 8'd1) begin n_bad++; $display("FAIL b2b_first_result: got q=%h r=%h want q=0b r=01", quotient, remainder); end
        // start still high in the done cycle: accepted as the next request
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
        $display("back_to_back: second q=%0d r=%0d lat=%0d", quotient, remainder, lat);
        n_vec++; if (lat != LAT_RUN) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, LAT_RUN); end
        n_vec++; if (quotient !== 8'd25 || remainder !== 8'd0) begin n_bad++; $display("FAIL b2b_second_result: got q=%h r=%h want q=19 r=00", quotient, remainder); end
    endtask

    task automatic test_reset_abort();
        int lat, bc, dcount; logic [7:0] q, r; logic z, bd;
        @(negedge clk);
        dividend = 8'd200; divisor = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);            // now in the 4th RUN cycle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("reset_abort: busy=%b done=%b q=%h r=%h", busy, done, quotient, remainder);
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_vec++; if (quotient !== 8'd0 || remainder !== 8'd0) begin n_bad++; $display("FAIL abort_results: got q=%h r=%h want 00 00", quotient, remainder); end
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        n_vec++; if (dcount != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dcount); end
        run_op(8'd17, 8'd4, lat, bc, q, r, z, bd);
        $display("reset_abort: 17/4 -> q=%0d r=%0d lat=%0d", q, r, lat);
        n_vec++; if (q !== 8'd4 || r !== 8'd1 || lat != LAT_RUN) begin n_bad++; $display("FAIL abort_next: got q=%h r=%h lat=%0d want q=04 r=01 lat=%0d", q, r, lat, LAT_RUN); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
`ifndef SEQ_DIVIDER8_SIGNED_EN
        test_boundaries();
`else
        test_signed();
`endif
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global time limit in case the design stalls somewhere unexpected.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
